l1_ahb_mtx_input_stage: RTL

Per-slave-port input stage of the L1 AHB bus matrix, sitting directly upstream of that port's address decoder. It captures the master's address-phase controls into a one-deep holding register whenever the decoder's target output stage cannot accept the transfer immediately. It stalls the master with HREADYOUTS low until the held transfer is accepted. It presents a single multiplexed live-or-held address phase to the decoder and returns the decoder's data-phase response to the master.

---
 rtl/l1_ahb_mtx_pkg.sv | 39 +++
 rtl/l1_ahb_mtx_addr_hold_reg.sv | 54 +++++
 rtl/l1_ahb_mtx_input_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/l1_ahb_mtx_pkg.sv
// Shared AHB bus-matrix types: HTRANS/HRESP encodings and the address-phase control bundle.
// Address and user sideband widths are set per instance, so they stay outside the struct.
package l1_ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   typedef struct packed {
      logic [1:0] trans;
      logic       write;
      logic [2:0] size;
      logic [2:0] burst;
      logic [3:0] prot;
      logic       mastlock;
   } ahb_ctrl_t;

   // A held beat may reach the slave after another master broke the burst,
   // so it has to restart the sequence as NONSEQ.
   function automatic logic [1:0] held_trans(input logic [1:0] trans);
      logic [1:0] res;
      res = trans;
      if (trans == HTRANS_SEQ) begin
         res = HTRANS_NONSEQ;
      end
      return res;
   endfunction

endpackage

// File: rtl/l1_ahb_mtx_addr_hold_reg.sv
// One-deep load-enabled holding register for a stalled address phase.
// The presented HTRANS has SEQ rewritten to NONSEQ.
module l1_ahb_mtx_addr_hold_reg
   import l1_ahb_mtx_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int AUSER_WIDTH = 32
) (
   input  logic                   clk_i,
   input  logic                   srst_i,
   input  logic                   load_i,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   input  logic [AUSER_WIDTH-1:0] auser_i,
   input  ahb_ctrl_t              ctrl_i,
   output logic [ADDR_WIDTH-1:0]  addr_o,
   output logic [AUSER_WIDTH-1:0] auser_o,
   output ahb_ctrl_t              ctrl_o
);

   logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
   logic [AUSER_WIDTH-1:0] auser_q, auser_d;
   ahb_ctrl_t              ctrl_q,  ctrl_d;

   always_comb begin
      addr_d  = addr_q;
      auser_d = auser_q;
      ctrl_d  = ctrl_q;
      if (load_i) begin
         addr_d  = addr_i;
         auser_d = auser_i;
         ctrl_d  = ctrl_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         addr_q  <= '0;
         auser_q <= '0;
         ctrl_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         auser_q <= auser_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      addr_o       = addr_q;
      auser_o      = auser_q;
      ctrl_o       = ctrl_q;
      ctrl_o.trans = held_trans(ctrl_q.trans);
   end

endmodule

// File: rtl/l1_ahb_mtx_input_stage.sv
// Per-slave-port input stage of the L1 AHB matrix: holds an address phase the output
// stage could not take, stalls the master meanwhile, and returns the data-phase response.
module l1_ahb_mtx_input_stage
   import l1_ahb_mtx_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int AUSER_WIDTH = 32
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   HSELS,
   input  logic [ADDR_WIDTH-1:0]  HADDRS,
   input  logic [1:0]             HTRANSS,
   input  logic                   HWRITES,
   input  logic [2:0]             HSIZES,
   input  logic [2:0]             HBURSTS,
   input  logic [3:0]             HPROTS,
   input  logic                   HMASTLOCKS,
   input  logic [AUSER_WIDTH-1:0] HAUSERS,
   input  logic                   HREADYS,
   output logic                   HREADYOUTS,
   output logic [1:0]             HRESPS,
   output logic                   sel_op,
   output logic [ADDR_WIDTH-1:0]  addr_op,
   output logic [1:0]             trans_op,
   output logic                   write_op,
   output logic [2:0]             size_op,
   output logic [2:0]             burst_op,
   output logic [3:0]             prot_op,
   output logic                   mastlock_op,
   output logic [AUSER_WIDTH-1:0] auser_op,
   output logic                   held_tran_op,
   input  logic                   active_ip,
   input  logic                   accept_ip,
   input  logic                   readyout_ip,
   input  logic [1:0]             resp_ip
);

   logic pend_q, pend_d;
   logic dphase_q, dphase_d;

   logic new_tran;
   logic err_first;
   logic cancel;
   logic aph_valid;
   logic aph_accept;
   logic capture;

   ahb_ctrl_t              live_ctrl;
   ahb_ctrl_t              held_ctrl;
   logic [ADDR_WIDTH-1:0]  held_addr;
   logic [AUSER_WIDTH-1:0] held_auser;

   always_comb begin
      live_ctrl          = '0;
      live_ctrl.trans    = HTRANSS;
      live_ctrl.write    = HWRITES;
      live_ctrl.size     = HSIZES;
      live_ctrl.burst    = HBURSTS;
      live_ctrl.prot     = HPROTS;
      live_ctrl.mastlock = HMASTLOCKS;
   end

   assign new_tran  = HSELS & HTRANSS[1] & HREADYS;
   assign err_first = (resp_ip == HRESP_ERROR) & ~readyout_ip;
   assign cancel    = pend_q & err_first;

   // A held transfer being cancelled is not offered, so it cannot be accepted either.
   assign aph_valid  = pend_q ? ~err_first : new_tran;
   assign aph_accept = aph_valid & active_ip & accept_ip;
   assign capture    = ~pend_q & new_tran & ~aph_accept;

   always_comb begin
      pend_d = pend_q;
      if (pend_q) begin
         if (aph_accept | cancel) begin
            pend_d = 1'b0;
         end
      end else begin
         pend_d = capture;
      end
   end

   always_comb begin
      dphase_d = dphase_q;
      if (aph_accept) begin
         dphase_d = 1'b1;
      end else if (readyout_ip) begin
         dphase_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         pend_q   <= 1'b0;
         dphase_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         dphase_q <= dphase_d;
      end
   end

   l1_ahb_mtx_addr_hold_reg #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .AUSER_WIDTH (AUSER_WIDTH)
   ) u_hold (
      .clk_i   (HCLK),
      .srst_i  (HRESET),
      .load_i  (capture),
      .addr_i  (HADDRS),
      .auser_i (HAUSERS),
      .ctrl_i  (live_ctrl),
      .addr_o  (held_addr),
      .auser_o (held_auser),
      .ctrl_o  (held_ctrl)
   );

   always_comb begin
      sel_op       = HSELS & HREADYS;
      addr_op      = HADDRS;
      trans_op     = live_ctrl.trans;
      write_op     = live_ctrl.write;
      size_op      = live_ctrl.size;
      burst_op     = live_ctrl.burst;
      prot_op      = live_ctrl.prot;
      mastlock_op  = live_ctrl.mastlock;
      auser_op     = HAUSERS;
      held_tran_op = 1'b0;
      if (pend_q) begin
         sel_op       = ~err_first;
         addr_op      = held_addr;
         trans_op     = held_ctrl.trans;
         write_op     = held_ctrl.write;
         size_op      = held_ctrl.size;
         burst_op     = held_ctrl.burst;
         prot_op      = held_ctrl.prot;
         mastlock_op  = held_ctrl.mastlock;
         auser_op     = held_auser;
         held_tran_op = 1'b1;
      end
      // Nothing is forwarded to the decoder while the port is held in reset.
      if (HRESET) begin
         sel_op   = 1'b0;
         trans_op = HTRANS_IDLE;
      end
   end

   always_comb begin
      HREADYOUTS = 1'b1;
      if (pend_q) begin
         HREADYOUTS = 1'b0;
      end else if (dphase_q) begin
         HREADYOUTS = readyout_ip;
      end
   end

   assign HRESPS = dphase_q ? resp_ip : HRESP_OKAY;

endmodule
